// File: rtl/activations_sequencer.sv
// Tile-level sequencer for the 32-row activation array: issues one start per tile,
// tracks row 0's valid to find tile end, steps the tile address and flags host collisions.
module activations_sequencer #(
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [4:0]  desc_last_row,
    input  logic [10:0] desc_addr_start,
    input  logic [10:0] desc_stride,
    input  logic [5:0]  desc_batch,
    input  logic [7:0]  desc_num_tiles,
    input  logic        abort,
    input  logic        host_access,
    input  logic        clr_err,
    input  logic [31:0] activation_in_valid,
    output logic        start,
    output logic [4:0]  last_row,
    output logic [10:0] addr_start,
    output logic [5:0]  batch,
    output logic        busy,
    output logic        done,
    output logic [7:0]  tiles_left,
    output logic        err_collision,
    output logic        err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_FIRST,
        S_STREAM,
        S_GAP,
        S_FINISH
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      last_row_q;
    logic [10:0]     addr_q;
    logic [10:0]     stride_q;
    logic [5:0]      batch_q;
    logic [7:0]      tiles_q;
    logic [WD_W-1:0] wd_cnt_q;
    logic [3:0]      gap_cnt_q;
    logic            err_coll_q;
    logic            err_tmo_q;

    logic row0_valid;
    logic accept;
    logic wd_expired;
    logic gap_done;
    logic aborting;
    logic unused_rows;

    // Only row 0 paces the tile; the other rows follow it inside the array.
    assign row0_valid  = activation_in_valid[0];
    assign unused_rows = &{1'b0, activation_in_valid[31:1]};

    assign accept     = desc_valid && (state_q == S_IDLE);
    assign wd_expired = (state_q == S_WAIT_FIRST) && !row0_valid
                        && (wd_cnt_q == WD_W'(TIMEOUT - 1));
    assign gap_done   = (gap_cnt_q == 4'(GAP_CYCLES - 1));
    assign aborting   = abort && (state_q != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = (desc_num_tiles == 8'd0) ? S_FINISH : S_ISSUE;
                end
            end
            S_ISSUE:      state_d = S_WAIT_FIRST;
            S_WAIT_FIRST: begin
                if (row0_valid) begin
                    state_d = S_STREAM;
                end else if (wd_expired) begin
                    state_d = S_IDLE;
                end
            end
            S_STREAM: begin
                if (!row0_valid) begin
                    state_d = (tiles_q != 8'd0) ? S_GAP : S_FINISH;
                end
            end
            S_GAP: begin
                if (gap_done) begin
                    state_d = S_ISSUE;
                end
            end
            S_FINISH:     state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
        if (aborting) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        desc_ready = (state_q == S_IDLE);
        busy       = (state_q != S_IDLE);
        start      = (state_q == S_ISSUE);
        done       = (state_q == S_FINISH);
    end

    // Tile parameters move only on accept or when a finished tile hands over to the gap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_row_q <= '0;
            addr_q     <= '0;
            stride_q   <= '0;
            batch_q    <= '0;
            tiles_q    <= '0;
            wd_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            err_coll_q <= 1'b0;
            err_tmo_q  <= 1'b0;
        end else begin
            if (accept) begin
                last_row_q <= desc_last_row;
                addr_q     <= desc_addr_start;
                stride_q   <= desc_stride;
                batch_q    <= desc_batch;
                tiles_q    <= desc_num_tiles;
            end

            if (aborting) begin
                tiles_q <= '0;
            end else if (state_q == S_ISSUE) begin
                tiles_q <= tiles_q - 8'd1;
            end

            if (!aborting && (state_q == S_STREAM) && !row0_valid && (tiles_q != 8'd0)) begin
                addr_q <= addr_q + stride_q;
            end

            if (state_q == S_ISSUE) begin
                wd_cnt_q <= '0;
            end else if (state_q == S_WAIT_FIRST) begin
                wd_cnt_q <= wd_cnt_q + 1'b1;
            end

            if (state_q == S_GAP) begin
                gap_cnt_q <= gap_cnt_q + 4'd1;
            end else begin
                gap_cnt_q <= '0;
            end

            if (host_access && busy) begin
                err_coll_q <= 1'b1;
            end else if (clr_err) begin
                err_coll_q <= 1'b0;
            end

            if (wd_expired && !aborting) begin
                err_tmo_q <= 1'b1;
            end else if (clr_err) begin
                err_tmo_q <= 1'b0;
            end
        end
    end

    assign last_row      = last_row_q;
    assign addr_start    = addr_q;
    assign batch         = batch_q;
    assign tiles_left    = tiles_q;
    assign err_collision = err_coll_q;
    assign err_timeout   = err_tmo_q;

endmodule

// File: tb/tb_activations_sequencer.sv
// Bench for activations_sequencer: descriptor table plus scoreboard of expected tile starts,
// and hand-built sequences for timeout, abort, collision and mid-gap reset.
module tb_activations_sequencer;

    localparam int GAP = 2;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        desc_valid;
    logic        desc_ready;
    logic [4:0]  desc_last_row;
    logic [10:0] desc_addr_start;
    logic [10:0] desc_stride;
    logic [5:0]  desc_batch;
    logic [7:0]  desc_num_tiles;
    logic        abort;
    logic        host_access;
    logic        clr_err;
    logic [31:0] activation_in_valid;
    logic        start;
    logic [4:0]  last_row;
    logic [10:0] addr_start;
    logic [5:0]  batch;
    logic        busy;
    logic        done;
    logic [7:0]  tiles_left;
    logic        err_collision;
    logic        err_timeout;

    activations_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_last_row(desc_last_row), .desc_addr_start(desc_addr_start),
        .desc_stride(desc_stride), .desc_batch(desc_batch), .desc_num_tiles(desc_num_tiles),
        .abort(abort), .host_access(host_access), .clr_err(clr_err),
        .activation_in_valid(activation_in_valid),
        .start(start), .last_row(last_row), .addr_start(addr_start), .batch(batch),
        .busy(busy), .done(done), .tiles_left(tiles_left),
        .err_collision(err_collision), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  lastRow;
        logic [10:0] addr;
        logic [5:0]  batch;
        logic [7:0]  tilesAfter;
    } tile_t;

    typedef struct {
        logic [4:0]  lastRow;
        logic [10:0] addr;
        logic [10:0] stride;
        logic [5:0]  batch;
        logic [7:0]  numTiles;
        int          tileLen;
        logic [10:0] expFinalAddr;
    } desc_vec_t;

    tile_t       expQ[$];
    tile_t       curTile;
    int          checks = 0;
    int          errors = 0;
    int          doneSeen = 0;
    logic        tilesPending = 1'b0;
    logic [7:0]  tilesExp;
    desc_vec_t   vecs[4];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: sample just after the edge and feed the scoreboard from any start seen.
    task automatic tick();
        @(posedge clk);
        #1;
        if (tilesPending) begin
            checkOutput("tiles_left_after_start", tiles_left, tilesExp);
            tilesPending = 1'b0;
        end
        if (done) doneSeen++;
        if (start) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_start: got start=1 expected 0");
            end else begin
                curTile = expQ.pop_front();
                checkOutput("start_last_row", last_row, curTile.lastRow);
                checkOutput("start_addr", addr_start, curTile.addr);
                checkOutput("start_batch", batch, curTile.batch);
                tilesPending = 1'b1;
                tilesExp     = curTile.tilesAfter;
            end
        end
    endtask

    task automatic applyStimulus(input desc_vec_t v, input int expStarts, output logic [10:0] lastAddr);
        int n;
        logic [10:0] a;
        n = 0;
        while (!desc_ready && n < 100) begin
            tick();
            n++;
        end
        if (!desc_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_wait: got desc_ready=0 expected 1 within 100 cycles");
        end
        a = v.addr;
        lastAddr = v.addr;
        for (int k = 0; k < expStarts; k++) begin
            expQ.push_back('{v.lastRow, a, v.batch, 8'(int'(v.numTiles) - 1 - k)});
            lastAddr = a;
            a = a + v.stride;
        end
        desc_valid      = 1'b1;
        desc_last_row   = v.lastRow;
        desc_addr_start = v.addr;
        desc_stride     = v.stride;
        desc_batch      = v.batch;
        desc_num_tiles  = v.numTiles;
        tick();
        desc_valid      = 1'b0;
        desc_num_tiles  = 8'hFF;
    endtask

    // Called in the ISSUE cycle; returns in the cycle where row 0 reads low.
    task automatic runTile(input int len);
        activation_in_valid = 32'h0000_0001;
        for (int i = 0; i < len; i++) begin
            tick();
            checkOutput("stable_last_row", last_row, curTile.lastRow);
            checkOutput("stable_addr", addr_start, curTile.addr);
            checkOutput("stable_batch", batch, curTile.batch);
            checkOutput("busy_in_tile", busy, 1);
        end
        activation_in_valid = 32'hFFFF_FFFE;
    endtask

    task automatic runDescriptor(input desc_vec_t v);
        logic [10:0] lastAddr;
        doneSeen = 0;
        applyStimulus(v, int'(v.numTiles), lastAddr);
        if (v.numTiles == 8'd0) begin
            checkOutput("zero_done_T1", done, 1);
            checkOutput("zero_no_start", start, 0);
            tick();
            checkOutput("zero_ready_T2", desc_ready, 1);
            checkOutput("zero_done_once", done, 0);
        end else begin
            for (int k = 0; k < int'(v.numTiles); k++) begin
                checkOutput("start_pulse", start, 1);
                checkOutput("busy_at_start", busy, 1);
                runTile(v.tileLen);
                if (k < int'(v.numTiles) - 1) begin
                    for (int g = 0; g < GAP; g++) begin
                        tick();
                        checkOutput("gap_no_start", start, 0);
                        checkOutput("gap_busy", busy, 1);
                    end
                    tick();
                end else begin
                    tick();
                    checkOutput("last_done", done, 1);
                    checkOutput("last_ready_low", desc_ready, 0);
                    tick();
                    checkOutput("ready_after_done", desc_ready, 1);
                    checkOutput("done_one_cycle", done, 0);
                end
            end
        end
        checkOutput("done_count", doneSeen, 1);
        checkOutput("final_addr", addr_start, v.expFinalAddr);
        checkOutput("final_addr_model", addr_start, lastAddr);
        checkOutput("sb_drained", expQ.size(), 0);
    endtask

    initial begin
        logic [10:0] la;
        vecs[0] = '{5'd31, 11'h010, 11'h000, 6'd4,  8'd1, 8, 11'h010};
        vecs[1] = '{5'd7,  11'h7F0, 11'h020, 6'd9,  8'd3, 4, 11'h030};
        vecs[2] = '{5'd3,  11'h100, 11'h055, 6'd2,  8'd0, 0, 11'h100};
        vecs[3] = '{5'd0,  11'h3FF, 11'h401, 6'd63, 8'd2, 2, 11'h000};

        reset = 1'b1;
        desc_valid = 1'b0; desc_last_row = '0; desc_addr_start = '0; desc_stride = '0;
        desc_batch = '0; desc_num_tiles = '0; abort = 1'b0; host_access = 1'b0;
        clr_err = 1'b0; activation_in_valid = 32'hFFFF_FFFE;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_ready", desc_ready, 1);
        checkOutput("rst_start", start, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_outputs", {last_row, addr_start, batch, tiles_left}, 0);
        checkOutput("rst_errs", {err_collision, err_timeout}, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) runDescriptor(vecs[i]);

        // Watchdog: row 0 never rises, so the tile is dropped without done.
        doneSeen = 0;
        applyStimulus('{5'd9, 11'h040, 11'h010, 6'd1, 8'd1, 0, 11'h040}, 1, la);
        checkOutput("tmo_start", start, 1);
        repeat (TMO) tick();
        checkOutput("tmo_busy_before", busy, 1);
        checkOutput("tmo_err_before", err_timeout, 0);
        tick();
        checkOutput("tmo_idle", busy, 0);
        checkOutput("tmo_err_set", err_timeout, 1);
        checkOutput("tmo_no_done", doneSeen, 0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("tmo_err_cleared", err_timeout, 0);

        // Abort during tile 2 of 4.
        doneSeen = 0;
        applyStimulus('{5'd12, 11'h020, 11'h010, 6'd5, 8'd4, 3, 11'h030}, 2, la);
        checkOutput("abort_start1", start, 1);
        runTile(3);
        repeat (GAP) tick();
        tick();
        checkOutput("abort_start2", start, 1);
        activation_in_valid = 32'h0000_0001;
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        activation_in_valid = 32'hFFFF_FFFE;
        checkOutput("abort_idle", busy, 0);
        checkOutput("abort_ready", desc_ready, 1);
        checkOutput("abort_tiles", tiles_left, 0);
        repeat (10) tick();
        checkOutput("abort_no_done", doneSeen, 0);
        checkOutput("abort_sb_drained", expQ.size(), 0);

        // Collision with simultaneous clear, then async reset in the gap.
        applyStimulus('{5'd1, 11'h200, 11'h004, 6'd3, 8'd2, 4, 11'h204}, 1, la);
        activation_in_valid = 32'h0000_0001;
        tick();
        host_access = 1'b1;
        clr_err     = 1'b1;
        tick();
        host_access = 1'b0;
        clr_err     = 1'b0;
        checkOutput("coll_set_over_clr", err_collision, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checkOutput("coll_cleared", err_collision, 0);
        tick();
        activation_in_valid = 32'hFFFF_FFFE;
        host_access = 1'b1;
        tick();
        host_access = 1'b0;
        checkOutput("gap_reached", busy, 1);
        checkOutput("gap_addr_stepped", addr_start, 11'h204);
        checkOutput("coll_set_again", err_collision, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_ready", desc_ready, 1);
        checkOutput("async_rst_pulses", {start, done}, 0);
        checkOutput("async_rst_outputs", {last_row, addr_start, batch, tiles_left}, 0);
        checkOutput("async_rst_errs", {err_collision, err_timeout}, 0);
        tick();
        reset = 1'b0;
        host_access = 1'b1;
        tick();
        host_access = 1'b0;
        checkOutput("coll_idle_ignored", err_collision, 0);
        repeat (6) tick();
        checkOutput("rst_sb_drained", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
